// File: rtl/shifter_seq.sv
// Multi-cycle shifter: moves the captured operand one bit per clock in
// LSL/LSR/ASR/ROR mode and holds the last result under a start/busy/done handshake.
module shifter_seq #(
  parameter int WIDTH = 8,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] d_in,
  input  logic [SHW-1:0]   shamt,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d_out
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [1:0] OP_LSL = 2'b00;
  localparam logic [1:0] OP_LSR = 2'b01;
  localparam logic [1:0] OP_ASR = 2'b10;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] work_q, work_d;
  logic [SHW-1:0]   cnt_q, cnt_d;
  logic [1:0]       op_q, op_d;
  logic [WIDTH-1:0] dout_q, dout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  function automatic logic [WIDTH-1:0] shift1(input logic [1:0] mode,
                                              input logic [WIDTH-1:0] w);
    case (mode)
      OP_LSL:  shift1 = {w[WIDTH-2:0], 1'b0};
      OP_LSR:  shift1 = {1'b0, w[WIDTH-1:1]};
      OP_ASR:  shift1 = {w[WIDTH-1], w[WIDTH-1:1]};
      default: shift1 = {w[0], w[WIDTH-1:1]};
    endcase
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      work_q  <= '0;
      cnt_q   <= '0;
      op_q    <= '0;
      dout_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      dout_q  <= dout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    dout_d  = dout_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          work_d  = d_in;
          cnt_d   = shamt;
          op_d    = op;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (cnt_q != '0) begin
          work_d = shift1(op_q, work_q);
          cnt_d  = cnt_q - SHW'(1);
        end else begin
          dout_d  = work_q;
          state_d = DONE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Flags are decoded from the next state so they come straight out of flops.
    busy_d = (state_d != IDLE);
    done_d = (state_d == DONE);
  end

  assign busy  = busy_q;
  assign done  = done_q;
  assign d_out = dout_q;

endmodule

// File: tb/tb_shifter_seq.sv
// Directed bench for shifter_seq at WIDTH=8 and WIDTH=16 with hand-computed results.
module tb_shifter_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        sel = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [15:0] d_in = 16'h0;
  logic [3:0]  shamt = 4'h0;

  logic        busy8, done8, busy16, done16;
  logic [7:0]  dout8;
  logic [15:0] dout16;

  logic        busy_s, done_s;
  logic [15:0] dout_s;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  shifter_seq #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .start(start & ~sel), .op(op),
    .d_in(d_in[7:0]), .shamt(shamt[2:0]),
    .busy(busy8), .done(done8), .d_out(dout8)
  );

  shifter_seq #(.WIDTH(16)) dut16 (
    .clk(clk), .reset(reset), .start(start & sel), .op(op),
    .d_in(d_in), .shamt(shamt),
    .busy(busy16), .done(done16), .d_out(dout16)
  );

  assign busy_s = sel ? busy16 : busy8;
  assign done_s = sel ? done16 : done8;
  assign dout_s = sel ? dout16 : {8'h00, dout8};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issues one request and follows it to completion; poke re-pulses start mid-SHIFT.
  task automatic run_op(input string tag, input logic s, input logic [1:0] o,
                        input logic [15:0] d, input logic [3:0] sh,
                        input logic [15:0] exp, input bit poke);
    int lat;
    int bcnt;
    sel   = s;
    op    = o;
    d_in  = d;
    shamt = sh;
    start = 1'b1;
    step();
    start = 1'b0;
    lat  = 1;
    bcnt = busy_s ? 1 : 0;
    while (!done_s && lat < 40) begin
      if (poke && lat == 2) begin
        start = 1'b1;
        op    = ~o;
        d_in  = ~d;
        shamt = 4'h1;
      end
      step();
      start = 1'b0;
      lat++;
      if (busy_s) bcnt++;
    end
    check({tag, "_dout"}, 32'(dout_s), 32'(exp));
    check({tag, "_lat"}, 32'(lat), 32'(sh) + 32'd2);
    check({tag, "_busycnt"}, 32'(bcnt), 32'(sh) + 32'd2);
    step();
    check({tag, "_done_clr"}, 32'(done_s), 32'd0);
    check({tag, "_busy_clr"}, 32'(busy_s), 32'd0);
    check({tag, "_hold"}, 32'(dout_s), 32'(exp));
  endtask

  initial begin
    int extra;
    repeat (3) step();
    reset = 1'b0;
    check("rst_busy8", 32'(busy8), 32'd0);
    check("rst_done8", 32'(done8), 32'd0);
    check("rst_dout8", 32'(dout8), 32'd0);
    check("rst_dout16", 32'(dout16), 32'd0);
    step();

    run_op("asr96_3", 1'b0, 2'b10, 16'h0096, 4'd3, 16'h00F2, 1'b0);
    run_op("lsr96_3", 1'b0, 2'b01, 16'h0096, 4'd3, 16'h0012, 1'b0);
    run_op("lsl96_3", 1'b0, 2'b00, 16'h0096, 4'd3, 16'h00B0, 1'b0);
    run_op("ror96_3", 1'b0, 2'b11, 16'h0096, 4'd3, 16'h00D2, 1'b0);
    run_op("asr80_7", 1'b0, 2'b10, 16'h0080, 4'd7, 16'h00FF, 1'b0);
    run_op("asr7f_7", 1'b0, 2'b10, 16'h007F, 4'd7, 16'h0000, 1'b0);
    run_op("lsl01_7", 1'b0, 2'b00, 16'h00FF, 4'd7, 16'h0080, 1'b0);
    // Back-to-back: each call starts in the cycle right after the previous busy drop.
    run_op("z_lsl", 1'b0, 2'b00, 16'h005A, 4'd0, 16'h005A, 1'b0);
    run_op("z_ror", 1'b0, 2'b11, 16'h005A, 4'd0, 16'h005A, 1'b0);
    run_op("poke", 1'b0, 2'b01, 16'h0096, 4'd3, 16'h0012, 1'b1);

    // Abort mid-SHIFT by reset.
    sel = 1'b0; op = 2'b10; d_in = 16'h0096; shamt = 4'd7; start = 1'b1;
    step();
    start = 1'b0;
    repeat (3) step();
    check("abort_busy_pre", 32'(busy8), 32'd1);
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("abort_busy", 32'(busy8), 32'd0);
    check("abort_done", 32'(done8), 32'd0);
    check("abort_dout", 32'(dout8), 32'd0);
    extra = 0;
    repeat (12) begin
      step();
      if (done8 || busy8) extra++;
    end
    check("abort_quiet", 32'(extra), 32'd0);

    run_op("w16_ror", 1'b1, 2'b11, 16'h8001, 4'd15, 16'h0003, 1'b0);
    run_op("w16_asr", 1'b1, 2'b10, 16'h8000, 4'd15, 16'hFFFF, 1'b0);
    run_op("w16_lsr", 1'b1, 2'b01, 16'h8000, 4'd15, 16'h0001, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/shifter_seq.md
# shifter_seq

Parametrised, multi-cycle sequential shifter, the successor to the fixed 8-bit combinational arithmetic right shifter. It supports four modes (LSL, LSR, ASR, ROR) on a WIDTH-bit operand and moves the operand one bit position per clock under a start/busy/done handshake. It serves datapaths that trade latency for area, where a full barrel network per bit is too costly, and it holds its last result stably for downstream logic.

## Interface
- WIDTH, default 8: operand width in bits; must be ≥ 2.
- SHW, default $clog2(WIDTH): shift-amount width; legal shamt range is 0..WIDTH-1.
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request strobe; sampled only in IDLE.
- op  input  2  mode: 00 LSL, 01 LSR, 10 ASR, 11 ROR.
- d_in  input  WIDTH  operand, captured on acceptance.
- shamt  input  SHW  shift amount, captured on acceptance.
- busy  output  1  high while state ≠ IDLE.
- done  output  1  one-cycle pulse when d_out is updated with a new result.
- d_out  output  WIDTH  last completed result; held until the next completion.

## Operation
- FSM states: IDLE, SHIFT, DONE. Internal registers: work[WIDTH], cnt[SHW], op_r[2].
- IDLE: if start=1, accept: work←d_in, cnt←shamt, op_r←op, go to SHIFT. Otherwise stay.
- Inputs are sampled only at acceptance. Changes to d_in, shamt or op afterwards have no effect.
- SHIFT, cnt≠0: shift work by one position per op_r, cnt←cnt−1, stay in SHIFT.
  - LSL: {work[W-2:0],0}
  - LSR: {0,work[W-1:1]}
  - ASR: {work[W-1],work[W-1:1]}
  - ROR: {work[0],work[W-1:1]}
- SHIFT, cnt=0: d_out←work, go to DONE.
- DONE: done=1 for this cycle only, go to IDLE unconditionally. A start seen in DONE is ignored.
- start while busy=1 is ignored. There is no queueing and no error flag.
- shamt=0 is legal: the result equals d_in and the normal handshake applies.
- ASR by WIDTH-1 yields all copies of the sign bit. LSL/LSR by WIDTH-1 leave only one surviving bit.
- Reset values: state=IDLE, busy=0, done=0, d_out=0, work=0, cnt=0, op_r=0.
- Reset has priority over all other activity. Reset mid-operation aborts the operation: the next cycle is IDLE with all outputs at reset values, and no done pulse is emitted for the aborted request.

## Timing
- Acceptance edge is E0, the first rising edge with state=IDLE and start=1.
- busy rises in the cycle after E0 and stays high for shamt+2 cycles (shamt+1 in SHIFT, 1 in DONE).
- d_out is updated at edge E(shamt+1). done=1 in the cycle following that edge, coincident with the new d_out.
- Total latency from acceptance to done: shamt+2 cycles. Worst case is WIDTH+1.
- busy falls in the cycle after done. A new start in that cycle is accepted immediately, so back-to-back throughput is one op per shamt+3 cycles.
- All outputs are registered. There are no combinational paths from inputs to outputs.

## Test plan
- WIDTH=8, ASR, d_in=0x96, shamt=3 -> d_out=0xF2. done pulses exactly 5 cycles after acceptance. busy is high for 5 cycles.
- WIDTH=8, LSR 0x96 by 3 -> 0x12. LSL 0x96 by 3 -> 0xB0. ROR 0x96 by 3 -> 0xD2. ASR 0x80 by 7 -> 0xFF. ASR 0x7F by 7 -> 0x00.
- shamt=0, any op, d_in=0x5A -> d_out=0x5A with done 2 cycles after acceptance. Back-to-back: a second start in the cycle after done is accepted.
- Start pulsed again during SHIFT with different d_in/op -> ignored. The first result is delivered unchanged and exactly one done pulse occurs.
- Reset asserted mid-SHIFT (ASR 0x96 by 7, after 3 cycles) -> next cycle busy=0, done=0, d_out=0x00, and no done pulse follows.
- WIDTH=16, ROR 0x8001 by 15 -> 0x0003. ASR 0x8000 by 15 -> 0xFFFF. done arrives 17 cycles after acceptance.
